sram_arbiter: RTL and testbench

- Shares the single off-chip 256x16 asynchronous SRAM between the processor core and the debug/boot-loader port.
- Arbitrates between the two requesters and sequences the active-low ce/oe/we strobes.
- Owns the tristate drive-enable for the bidirectional data bus, so bus contention cannot occur.
- Sits between the core's memory interface and the board-level SRAM pins, replacing the glue logic (oe = MemWrite, we = !MemWrite) currently handled on the PCB.

---
 rtl/sram_arb_pkg.sv | 21 ++
 rtl/sram_arbiter_if.sv | 52 +++++
 rtl/rr_arb2.sv | 21 ++
 rtl/sram_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter.
package sram_arb_pkg;

    // Width of the wait-state counter (supports WAIT_STATES 0..7).
    localparam int WS_W = 3;

    // Requester identifiers.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    // Arbiter/strobe sequencer states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_WSETUP = 3'd2,
        S_WPULSE = 3'd3,
        S_WHOLD  = 3'd4,
        S_ACK    = 3'd5
    } state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundles both requester ports and the SRAM pad signals.
// slave  = the arbiter side, master = requesters plus the pad.
interface sram_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          p_req;
    logic          p_we;
    logic [AW-1:0] p_adr;
    logic [DW-1:0] p_wdata;
    logic [DW-1:0] p_rdata;
    logic          p_ack;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_adr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;

    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic [AW-1:0] sram_adr;
    logic [DW-1:0] sram_dout;
    logic          sram_doe;
    logic [DW-1:0] sram_din;

    logic          busy;
    logic          owner;

    modport slave (
        input  p_req, p_we, p_adr, p_wdata,
        output p_rdata, p_ack,
        input  d_req, d_we, d_adr, d_wdata,
        output d_rdata, d_ack,
        output sram_ce_n, sram_oe_n, sram_we_n, sram_adr, sram_dout, sram_doe,
        input  sram_din,
        output busy, owner
    );

    modport master (
        output p_req, p_we, p_adr, p_wdata,
        input  p_rdata, p_ack,
        output d_req, d_we, d_adr, d_wdata,
        input  d_rdata, d_ack,
        input  sram_ce_n, sram_oe_n, sram_we_n, sram_adr, sram_dout, sram_doe,
        output sram_din,
        input  busy, owner
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie, grants the requester that was
// not granted last time. Purely combinational.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // Debug wins when it is the only requester, or on a tie after a CPU grant.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = REQ_CPU;
        if (req[REQ_DBG] && (!req[REQ_CPU] || (last == REQ_CPU))) begin
            gnt_id = REQ_DBG;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the CPU and debug ports onto one asynchronous SRAM and
// sequences ce/oe/we plus the pad drive enable. Every output comes from a
// register whose next value is decoded from the next state, so the pins
// change cleanly on the same edge as the state.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW          = 8,
    parameter int DW          = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic          clk1,
    input  logic          reset,
    sram_arbiter_if.slave bus
);

    localparam logic [WS_W-1:0] WS_LOAD = WS_W'(WAIT_STATES);

    state_t          state_reg, state_next;
    logic [WS_W-1:0] wait_reg, wait_next;
    logic            last_reg;
    logic            owner_reg;
    logic [AW-1:0]   adr_reg;
    logic [DW-1:0]   dout_reg;
    logic            ce_n_reg, oe_n_reg, we_n_reg, doe_reg, busy_reg;
    logic            ce_n_next, oe_n_next, we_n_next, doe_next;
    logic            ack_reg   [2];
    logic [DW-1:0]   rdata_reg [2];

    logic [1:0]      req_vec;
    logic            gnt_valid, gnt_id;
    logic            gnt_we;
    logic [AW-1:0]   gnt_adr;
    logic [DW-1:0]   gnt_wdata;
    logic            grant;
    logic            rd_done;

    // A requester whose ack is high this cycle is not eligible (no double issue).
    assign req_vec[REQ_CPU] = bus.p_req & ~ack_reg[REQ_CPU];
    assign req_vec[REQ_DBG] = bus.d_req & ~ack_reg[REQ_DBG];

    rr_arb2 u_rr (
        .req       (req_vec),
        .last      (last_reg),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Select the granted requester's command and decode grant/read-done events.
    always_comb begin
        gnt_we    = (gnt_id == REQ_DBG) ? bus.d_we    : bus.p_we;
        gnt_adr   = (gnt_id == REQ_DBG) ? bus.d_adr   : bus.p_adr;
        gnt_wdata = (gnt_id == REQ_DBG) ? bus.d_wdata : bus.p_wdata;
        grant     = (state_reg == S_IDLE) && gnt_valid;
        rd_done   = (state_reg == S_RD) && (wait_reg == '0);
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        case (state_reg)
            S_IDLE: begin
                if (gnt_valid) begin
                    state_next = gnt_we ? S_WSETUP : S_RD;
                    wait_next  = WS_LOAD;
                end
            end
            S_RD: begin
                if (wait_reg == '0) state_next = S_ACK;
                else                wait_next  = wait_reg - 1'b1;
            end
            S_WSETUP: begin
                state_next = S_WPULSE;
                wait_next  = WS_LOAD;
            end
            S_WPULSE: begin
                if (wait_reg == '0) state_next = S_WHOLD;
                else                wait_next  = wait_reg - 1'b1;
            end
            S_WHOLD:  state_next = S_ACK;
            S_ACK:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Strobe values for the state being entered; doe never overlaps RD.
    always_comb begin
        ce_n_next = 1'b1;
        oe_n_next = 1'b1;
        we_n_next = 1'b1;
        doe_next  = 1'b0;
        case (state_next)
            S_RD: begin
                ce_n_next = 1'b0;
                oe_n_next = 1'b0;
            end
            S_WSETUP, S_WHOLD: begin
                ce_n_next = 1'b0;
                doe_next  = 1'b1;
            end
            S_WPULSE: begin
                ce_n_next = 1'b0;
                we_n_next = 1'b0;
                doe_next  = 1'b1;
            end
            default: ;
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
        end
    end

    // Latch the granted command; these registers also drive the pad address/data.
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            last_reg  <= REQ_DBG;   // makes the first tie go to the CPU
            owner_reg <= REQ_CPU;
            adr_reg   <= '0;
            dout_reg  <= '0;
        end else if (grant) begin
            last_reg  <= gnt_id;
            owner_reg <= gnt_id;
            adr_reg   <= gnt_adr;
            if (gnt_we) dout_reg <= gnt_wdata;
        end
    end

    // Registered strobes, pad enable and busy flag.
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            ce_n_reg <= 1'b1;
            oe_n_reg <= 1'b1;
            we_n_reg <= 1'b1;
            doe_reg  <= 1'b0;
            busy_reg <= 1'b0;
        end else begin
            ce_n_reg <= ce_n_next;
            oe_n_reg <= oe_n_next;
            we_n_reg <= we_n_next;
            doe_reg  <= doe_next;
            busy_reg <= (state_next != S_IDLE);
        end
    end

    // Per-requester ack pulse and read-data capture; only the owner is touched.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        always_ff @(posedge clk1 or negedge reset) begin
            if (!reset) begin
                ack_reg[gi]   <= 1'b0;
                rdata_reg[gi] <= '0;
            end else begin
                ack_reg[gi] <= (state_next == S_ACK) && (owner_reg == 1'(gi));
                if (rd_done && (owner_reg == 1'(gi))) begin
                    rdata_reg[gi] <= bus.sram_din;
                end
            end
        end
    end

    assign bus.p_ack     = ack_reg[REQ_CPU];
    assign bus.p_rdata   = rdata_reg[REQ_CPU];
    assign bus.d_ack     = ack_reg[REQ_DBG];
    assign bus.d_rdata   = rdata_reg[REQ_DBG];
    assign bus.sram_ce_n = ce_n_reg;
    assign bus.sram_oe_n = oe_n_reg;
    assign bus.sram_we_n = we_n_reg;
    assign bus.sram_doe  = doe_reg;
    assign bus.sram_adr  = adr_reg;
    assign bus.sram_dout = dout_reg;
    assign bus.busy      = busy_reg;
    assign bus.owner     = owner_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus random
// two-requester traffic against a transaction-level arbitration model.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int WS     = 2;
    localparam int RD_LAT = 2 + WS;
    localparam int WR_LAT = 4 + WS;

    logic clk1 = 1'b0;
    logic reset;
    always #5 clk1 = ~clk1;

    sram_arbiter_if #(.AW(8), .DW(16)) bus ();

    sram_arbiter #(.AW(8), .DW(16), .WAIT_STATES(WS)) dut (
        .clk1  (clk1),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- SRAM chip model (the pad side) ----------------
    logic [15:0] sram_mem [256];
    assign bus.sram_din = (!bus.sram_ce_n && !bus.sram_oe_n) ? sram_mem[bus.sram_adr] : 16'hDEAD;
    always @(posedge clk1) begin
        if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_doe) sram_mem[bus.sram_adr] <= bus.sram_dout;
    end

    // ---------------- reference model state ----------------
    logic [15:0] ref_mem [256];
    int          cyc = 0;
    logic        rq [2];
    logic        rq_we [2];
    logic [7:0]  rq_adr [2];
    logic [15:0] rq_wd [2];
    logic        granted [2];
    logic        gnt_we [2];
    int          exp_ack [2];
    logic [15:0] exp_rd [2];
    logic [15:0] model_rd [2];
    int          m_ack_cyc [2];
    int          seen_ack [2];
    int          idle_at = 0;
    int          grant_cyc = -100;
    int          m_last = 1;
    int          m_owner = 0;
    int          ack_log [$];

    task automatic drive_pins();
        bus.p_req = rq[0]; bus.p_we = rq_we[0]; bus.p_adr = rq_adr[0]; bus.p_wdata = rq_wd[0];
        bus.d_req = rq[1]; bus.d_we = rq_we[1]; bus.d_adr = rq_adr[1]; bus.d_wdata = rq_wd[1];
    endtask

    // Server model: when free, pick a pending requester (alternate on a tie),
    // then the arbiter is busy for a fixed read/write duration plus ACK.
    task automatic model_arb();
        logic p0, p1;
        int   pick;
        p0 = rq[0] && !granted[0];
        p1 = rq[1] && !granted[1];
        if (cyc >= idle_at && (p0 || p1)) begin
            pick = (p0 && p1) ? (1 - m_last) : (p0 ? 0 : 1);
            granted[pick] = 1'b1;
            gnt_we[pick]  = rq_we[pick];
            if (rq_we[pick]) begin
                ref_mem[rq_adr[pick]] = rq_wd[pick];
                exp_ack[pick] = cyc + WR_LAT;
            end else begin
                exp_rd[pick]  = ref_mem[rq_adr[pick]];
                exp_ack[pick] = cyc + RD_LAT;
            end
            idle_at   = exp_ack[pick] + 1;
            grant_cyc = cyc;
            m_last    = pick;
            m_owner   = pick;
        end
    endtask

    task automatic observe();
        logic a;
        for (int r = 0; r < 2; r++) begin
            a = (r == 1) ? bus.d_ack : bus.p_ack;
            if (a) begin
                seen_ack[r] = cyc;
                ack_log.push_back(r);
            end
            check((r == 1) ? "d_ack" : "p_ack", a, (cyc == exp_ack[r]));
            if (cyc == exp_ack[r]) begin
                if (!gnt_we[r]) model_rd[r] = exp_rd[r];
                $display("txn req=%0d we=%0d cyc=%0d rdata=%h", r, gnt_we[r], cyc, model_rd[r]);
                rq[r] = 1'b0; granted[r] = 1'b0; exp_ack[r] = -1; m_ack_cyc[r] = cyc;
            end
        end
        check("p_rdata", bus.p_rdata, model_rd[0]);
        check("d_rdata", bus.d_rdata, model_rd[1]);
        check("owner", bus.owner, m_owner);
        check("busy", bus.busy, (cyc > grant_cyc && cyc < idle_at));
    endtask

    task automatic step();
        drive_pins();
        model_arb();
        @(posedge clk1); #1; cyc++;
        observe();
    endtask

    task automatic issue(input int r, input logic we, input logic [7:0] adr, input logic [15:0] wd);
        rq[r] = 1'b1; rq_we[r] = we; rq_adr[r] = adr; rq_wd[r] = wd;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((rq[0] || rq[1] || cyc < idle_at) && n < budget) begin
            step();
            n++;
        end
        if (rq[0] || rq[1] || cyc < idle_at) check("timeout", 1, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int r = 0; r < 2; r++) begin
            rq[r] = 1'b0; rq_we[r] = 1'b0; rq_adr[r] = '0; rq_wd[r] = '0;
            granted[r] = 1'b0; gnt_we[r] = 1'b0; exp_ack[r] = -1; model_rd[r] = '0;
            m_ack_cyc[r] = -1; seen_ack[r] = -1;
        end
        m_last = 1; m_owner = 0; grant_cyc = -100;
        drive_pins();
        #1;
        check("rst_ce_n", bus.sram_ce_n, 1);
        check("rst_oe_n", bus.sram_oe_n, 1);
        check("rst_we_n", bus.sram_we_n, 1);
        check("rst_doe", bus.sram_doe, 0);
        check("rst_p_ack", bus.p_ack, 0);
        check("rst_d_ack", bus.d_ack, 0);
        check("rst_p_rdata", bus.p_rdata, 0);
        check("rst_d_rdata", bus.d_rdata, 0);
        check("rst_adr", bus.sram_adr, 0);
        check("rst_dout", bus.sram_dout, 0);
        check("rst_owner", bus.owner, 0);
        check("rst_busy", bus.busy, 0);
        repeat (2) begin @(posedge clk1); #1; cyc++; end
        check("rst_hold_ce_n", bus.sram_ce_n, 1);
        reset   = 1'b1;
        idle_at = cyc;
    endtask

    // ---------------- protocol monitor ----------------
    logic       prev_we_n = 1'b1, prev_doe = 1'b0, prev_ce_n = 1'b1;
    logic       prev_pack = 1'b0, prev_dack = 1'b0, wr_pend = 1'b0;
    logic [7:0] prev_adr = '0;
    always @(negedge clk1) begin
        check("oe_with_doe", (!bus.sram_oe_n && bus.sram_doe), 0);
        check("p_ack_width", (bus.p_ack && prev_pack), 0);
        check("d_ack_width", (bus.d_ack && prev_dack), 0);
        check("ack_overlap", (bus.p_ack && bus.d_ack), 0);
        if (!bus.sram_we_n && prev_we_n)
            check("we_setup", (prev_doe && !prev_ce_n && prev_adr == bus.sram_adr), 1);
        if (!bus.sram_oe_n) check("wr_rd_gap", wr_pend, 0);
        if (!bus.sram_we_n) wr_pend = 1'b1;
        else if (bus.sram_ce_n && bus.sram_oe_n) wr_pend = 1'b0;
        prev_we_n = bus.sram_we_n; prev_doe = bus.sram_doe; prev_ce_n = bus.sram_ce_n;
        prev_adr  = bus.sram_adr;  prev_pack = bus.p_ack;  prev_dack = bus.d_ack;
    end

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        int budget;
        logic [15:0] v;
        int mism;

        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            sram_mem[i] = v;
            ref_mem[i]  = v;
        end
        reset = 1'b1;
        #1;
        do_reset();

        // Write then read back through the CPU port.
        issue(0, 1'b1, 8'h3C, 16'hBEEF);
        t0 = cyc;
        wait_idle(100);
        check("wr_latency", seen_ack[0] - t0, WR_LAT);
        issue(0, 1'b0, 8'h3C, 16'h0000);
        t0 = cyc;
        wait_idle(100);
        check("rd_latency", seen_ack[0] - t0, RD_LAT);
        check("rd_beef", bus.p_rdata, 16'hBEEF);

        // Tie straight out of reset: CPU first, then debug.
        do_reset();
        ack_log.delete();
        issue(0, 1'b0, 8'h01, 16'h0);
        issue(1, 1'b0, 8'h02, 16'h0);
        wait_idle(100);
        check("tie_count", ack_log.size(), 2);
        if (ack_log.size() >= 2) begin
            check("tie_first", ack_log[0], 0);
            check("tie_second", ack_log[1], 1);
        end
        check("tie_d_rdata", bus.d_rdata, ref_mem[8'h02]);
        check("tie_p_keep", bus.p_rdata, ref_mem[8'h01]);

        // Requester inputs change right after grant; latched command must win.
        issue(0, 1'b1, 8'h10, 16'h1234);
        step();
        rq_adr[0] = 8'hFF;
        rq_wd[0]  = 16'h0000;
        wait_idle(100);
        check("latch_adr10", sram_mem[8'h10], 16'h1234);
        check("latch_adrFF", sram_mem[8'hFF], ref_mem[8'hFF]);

        // Reset in the second cycle of a read.
        issue(0, 1'b0, 8'h05, 16'h0);
        step();
        step();
        check("mid_rd_oe", bus.sram_oe_n, 0);
        do_reset();
        issue(0, 1'b0, 8'h3C, 16'h0);
        wait_idle(100);
        check("post_rst_rd", bus.p_rdata, 16'hBEEF);

        // Both requesters re-request continuously: grants must alternate.
        ack_log.delete();
        budget = 0;
        while (ack_log.size() < 20 && budget < 2000) begin
            for (int r = 0; r < 2; r++)
                if (!rq[r] && m_ack_cyc[r] != cyc)
                    issue(r, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
            step();
            budget++;
        end
        wait_idle(200);
        check("alt_count", (ack_log.size() >= 20), 1);
        for (int i = 1; i < 20 && i < ack_log.size(); i++)
            check("alternate", (ack_log[i] != ack_log[i-1]), 1);

        // Random sparse traffic.
        for (int n = 0; n < 300; n++) begin
            for (int r = 0; r < 2; r++)
                if (!rq[r] && m_ack_cyc[r] != cyc && $urandom_range(0, 99) < 40)
                    issue(r, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
            step();
        end
        wait_idle(200);

        mism = 0;
        for (int i = 0; i < 256; i++) if (sram_mem[i] !== ref_mem[i]) mism++;
        check("mem_final", mism, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
